// File: rtl/fpu_seq_if.sv
// fpu_seq_if: request, FPU, response and CSR signals of the FPU issue sequencer
interface fpu_seq_if #(parameter int TAGW = 5);
  logic            req_valid;
  logic            req_ready;
  logic [5:0]      req_op;
  logic [2:0]      req_rm;
  logic [31:0]     req_rs1;
  logic [31:0]     req_rs2;
  logic [TAGW-1:0] req_tag;
  logic [5:0]      fpu_op;
  logic [31:0]     fpu_rs1;
  logic [31:0]     fpu_rs2;
  logic [2:0]      fpu_frm;
  logic [31:0]     fpu_result;
  logic [4:0]      fpu_flags;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_result;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_illegal;
  logic            csr_we;
  logic [7:0]      csr_wdata;
  logic [7:0]      fcsr;
  modport master (
    output req_valid, req_op, req_rm, req_rs1, req_rs2, req_tag,
    output fpu_result, fpu_flags, rsp_ready, csr_we, csr_wdata,
    input  req_ready, fpu_op, fpu_rs1, fpu_rs2, fpu_frm,
    input  rsp_valid, rsp_result, rsp_tag, rsp_illegal, fcsr
  );
  modport slave (
    input  req_valid, req_op, req_rm, req_rs1, req_rs2, req_tag,
    input  fpu_result, fpu_flags, rsp_ready, csr_we, csr_wdata,
    output req_ready, fpu_op, fpu_rs1, fpu_rs2, fpu_frm,
    output rsp_valid, rsp_result, rsp_tag, rsp_illegal, fcsr
  );
endinterface

// File: rtl/fpu_seq.sv
// fpu_seq: single-op issue sequencer for the FPU; holds operands for a fixed latency and owns fcsr
module fpu_seq #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 12,
  parameter int TAGW     = 5
) (
  input logic      clk,
  input logic      resetn,
  fpu_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]      state;
  logic [15:0]     cnt;
  logic [15:0]     lat;
  logic [2:0]      frm_res;
  logic            illegal;
  logic            accept;
  logic            capture;
  logic [5:0]      op_q;
  logic [31:0]     rs1_q;
  logic [31:0]     rs2_q;
  logic [2:0]      frm_q;
  logic [31:0]     result_q;
  logic [TAGW-1:0] tag_q;
  logic            illegal_q;
  logic [7:0]      fcsr_q;
  always_comb begin
    lat = bus.req_op == 6'd0 ? 16'(LAT_ADD) :
          bus.req_op == 6'd1 ? 16'(LAT_MUL) :
          bus.req_op == 6'd2 ? 16'(LAT_DIV) :
          bus.req_op == 6'd3 ? 16'(LAT_SQRT) : 16'd1;
    // dynamic rm reads the registered frm, so a same-cycle csr write is not seen
    frm_res = bus.req_rm == 3'd7 ? fcsr_q[7:5] : bus.req_rm;
    illegal = bus.req_op > 6'd16 || frm_res > 3'd4;
    accept  = bus.req_valid && state == IDLE;
    capture = state == EXEC && cnt == '0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      frm_q     <= '0;
      result_q  <= '0;
      tag_q     <= '0;
      illegal_q <= 1'b0;
      fcsr_q    <= '0;
    end else begin
      if (accept) begin
        state     <= illegal ? DONE : EXEC;
        cnt       <= lat - 16'd1;
        tag_q     <= bus.req_tag;
        illegal_q <= illegal;
        if (illegal)
          result_q <= '0;
        else begin
          op_q  <= bus.req_op;
          rs1_q <= bus.req_rs1;
          rs2_q <= bus.req_rs2;
          frm_q <= frm_res;
        end
      end else if (capture) begin
        state    <= DONE;
        result_q <= bus.fpu_result;
      end else if (state == EXEC)
        cnt <= cnt - 16'd1;
      else if (state == DONE && bus.rsp_ready)
        state <= IDLE;
      if (bus.csr_we)
        fcsr_q <= bus.csr_wdata | {3'b000, capture ? bus.fpu_flags : 5'd0};
      else if (capture)
        fcsr_q[4:0] <= fcsr_q[4:0] | bus.fpu_flags;
    end
  assign bus.req_ready   = state == IDLE;
  assign bus.rsp_valid   = state == DONE;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_tag     = tag_q;
  assign bus.rsp_illegal = illegal_q;
  assign bus.fpu_op      = op_q;
  assign bus.fpu_rs1     = rs1_q;
  assign bus.fpu_rs2     = rs2_q;
  assign bus.fpu_frm     = frm_q;
  assign bus.fcsr        = fcsr_q;
endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: vector table, hand sequences and randomized ops against a reference model of fpu_seq
module tb_fpu_seq;
  localparam logic [31:0] GARB = 32'hDEADBEEF;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  m_fcsr = 8'h00;
  logic [5:0]  m_op = '0;
  logic [31:0] m_rs1 = '0;
  logic [31:0] m_rs2 = '0;
  logic [2:0]  m_frm = '0;
  always #5 clk = ~clk;
  fpu_seq_if #(.TAGW(5)) bus ();
  fpu_seq #(.LAT_ADD(3), .LAT_MUL(3), .LAT_DIV(12), .LAT_SQRT(12), .TAGW(5)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  typedef struct {
    logic        pre_we;
    logic [7:0]  pre;
    logic [5:0]  op;
    logic [2:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  tag;
    logic [4:0]  fl;
    logic        ill;
    logic [2:0]  frm;
    logic [7:0]  fcsr;
  } vec_t;
  vec_t vecs [10];
  function automatic int lat_of(logic [5:0] op);
    case (op)
      6'd0, 6'd1: return 3;
      6'd2, 6'd3: return 12;
      default:    return 1;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic csr_write(input logic [7:0] v);
    bus.csr_we = 1'b1;
    bus.csr_wdata = v;
    tick();
    bus.csr_we = 1'b0;
    m_fcsr = v;
    chk("csr_write_fcsr", bus.fcsr, v);
  endtask
  task automatic run_op(input logic [5:0] op, input logic [2:0] rm, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input logic [31:0] res, input logic [4:0] fl,
                        input logic csr_cap, input logic [7:0] csr_val,
                        input logic exp_ill, input logic [2:0] exp_frm, input logic [7:0] exp_fcsr,
                        input int hold, input logic pend);
    int l;
    l = lat_of(op);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_rm = rm;
    bus.req_rs1 = a;
    bus.req_rs2 = b;
    bus.req_tag = tg;
    tick();
    bus.req_valid = 1'b0;
    if (exp_ill) begin
      chk("ill_rsp_valid", bus.rsp_valid, 1);
      chk("ill_flag", bus.rsp_illegal, 1);
      chk("ill_result", bus.rsp_result, 0);
      chk("ill_fpu_op_kept", bus.fpu_op, m_op);
      chk("ill_fpu_rs1_kept", bus.fpu_rs1, m_rs1);
      chk("ill_fpu_frm_kept", bus.fpu_frm, m_frm);
    end else begin
      m_op = op; m_rs1 = a; m_rs2 = b; m_frm = exp_frm;
      for (int k = 1; k <= l; k++) begin
        chk("busy_rsp_valid", bus.rsp_valid, 0);
        chk("busy_req_ready", bus.req_ready, 0);
        chk("exec_fpu_op", bus.fpu_op, op);
        chk("exec_fpu_rs1", bus.fpu_rs1, a);
        chk("exec_fpu_rs2", bus.fpu_rs2, b);
        chk("exec_fpu_frm", bus.fpu_frm, exp_frm);
        if (k == l) begin
          bus.fpu_result = res;
          bus.fpu_flags = fl;
          bus.csr_we = csr_cap;
          bus.csr_wdata = csr_val;
        end
        tick();
        bus.fpu_result = GARB;
        bus.fpu_flags = 5'h1F;
        bus.csr_we = 1'b0;
      end
      chk("done_rsp_valid", bus.rsp_valid, 1);
      chk("done_result", bus.rsp_result, res);
      chk("done_illegal", bus.rsp_illegal, 0);
      chk("done_fpu_op_held", bus.fpu_op, op);
    end
    chk("rsp_tag", bus.rsp_tag, tg);
    chk("fcsr_after", bus.fcsr, exp_fcsr);
    m_fcsr = exp_fcsr;
    if (pend) begin
      bus.req_valid = 1'b1;
      bus.req_op = 6'd30;
      bus.req_rm = 3'd0;
      bus.req_tag = 5'd21;
    end
    bus.rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_result", bus.rsp_result, exp_ill ? 32'h0 : res);
      chk("hold_tag", bus.rsp_tag, tg);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("hs_rsp_valid_low", bus.rsp_valid, 0);
    chk("hs_req_ready_high", bus.req_ready, 1);
  endtask
  initial begin
    vecs[0] = '{1'b0, 8'h00, 6'd0,  3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 5'd7,  5'h00, 1'b0, 3'd0, 8'h00};
    vecs[1] = '{1'b1, 8'h60, 6'd1,  3'd7, 32'h40000000, 32'h40400000, 32'h40C00000, 5'd3,  5'h00, 1'b0, 3'd3, 8'h60};
    vecs[2] = '{1'b1, 8'hA0, 6'd1,  3'd7, 32'h40000000, 32'h40400000, 32'h40C00000, 5'd4,  5'h00, 1'b1, 3'd0, 8'hA0};
    vecs[3] = '{1'b1, 8'h00, 6'd2,  3'd1, 32'h3F800000, 32'h40000000, 32'h3F000000, 5'd9,  5'h08, 1'b0, 3'd1, 8'h08};
    vecs[4] = '{1'b0, 8'h00, 6'd1,  3'd2, 32'h40400000, 32'h40400000, 32'h41100000, 5'd10, 5'h01, 1'b0, 3'd2, 8'h09};
    vecs[5] = '{1'b0, 8'h00, 6'd20, 3'd0, 32'h11111111, 32'h22222222, 32'h33333333, 5'd11, 5'h00, 1'b1, 3'd0, 8'h09};
    vecs[6] = '{1'b0, 8'h00, 6'd5,  3'd4, 32'h0000ABCD, 32'h00001234, 32'hCAFEF00D, 5'd12, 5'h04, 1'b0, 3'd4, 8'h0D};
    vecs[7] = '{1'b0, 8'h00, 6'd16, 3'd6, 32'h1, 32'h2, 32'h3, 5'd13, 5'h00, 1'b1, 3'd0, 8'h0D};
    vecs[8] = '{1'b0, 8'h00, 6'd17, 3'd0, 32'h1, 32'h2, 32'h3, 5'd14, 5'h00, 1'b1, 3'd0, 8'h0D};
    vecs[9] = '{1'b0, 8'h00, 6'd3,  3'd3, 32'h40800000, 32'h0, 32'h40000000, 5'd15, 5'h02, 1'b0, 3'd3, 8'h0F};
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rm = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_tag = '0;
    bus.fpu_result = GARB; bus.fpu_flags = 5'h1F; bus.rsp_ready = 1'b0; bus.csr_we = 1'b0; bus.csr_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_tag", bus.rsp_tag, 0);
    chk("rst_rsp_illegal", bus.rsp_illegal, 0);
    chk("rst_fpu_op", bus.fpu_op, 0);
    chk("rst_fpu_frm", bus.fpu_frm, 0);
    chk("rst_fcsr", bus.fcsr, 0);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_we) csr_write(vecs[i].pre);
      run_op(vecs[i].op, vecs[i].rm, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res, vecs[i].fl,
             1'b0, 8'h00, vecs[i].ill, vecs[i].frm, vecs[i].fcsr, i % 3, 1'b0);
    end
    // capture edge coinciding with a csr write: written value wins, new flags still accrue
    csr_write(8'h2F);
    run_op(6'd0, 3'd0, 32'h1, 32'h2, 5'd1, 32'h12345678, 5'h10, 1'b1, 8'h00, 1'b0, 3'd0, 8'h10, 0, 1'b0);
    // backpressure with a pending request that may only be taken after the handshake
    run_op(6'd1, 3'd2, 32'h5, 32'h6, 5'd2, 32'h0BADF00D, 5'h00, 1'b0, 8'h00, 1'b0, 3'd2, 8'h10, 10, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    chk("pend_rsp_valid", bus.rsp_valid, 1);
    chk("pend_illegal", bus.rsp_illegal, 1);
    chk("pend_tag", bus.rsp_tag, 21);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("pend_hs_req_ready", bus.req_ready, 1);
    // reset five cycles into an fsqrt
    csr_write(8'h25);
    bus.req_valid = 1'b1; bus.req_op = 6'd3; bus.req_rm = 3'd0; bus.req_rs1 = 32'h41100000; bus.req_tag = 5'd5;
    tick();
    bus.req_valid = 1'b0;
    bus.fpu_flags = 5'h1F;
    for (int k = 0; k < 5; k++) tick();
    resetn = 1'b0;
    #1;
    chk("mid_rst_req_ready", bus.req_ready, 1);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_rsp_tag", bus.rsp_tag, 0);
    chk("mid_rst_fpu_op", bus.fpu_op, 0);
    chk("mid_rst_fpu_rs1", bus.fpu_rs1, 0);
    chk("mid_rst_fpu_frm", bus.fpu_frm, 0);
    chk("mid_rst_fcsr", bus.fcsr, 0);
    tick();
    resetn = 1'b1;
    m_fcsr = 8'h00; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_frm = '0;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("post_rst_no_rsp", bus.rsp_valid, 0);
    end
    chk("post_rst_fcsr", bus.fcsr, 0);
    run_op(6'd0, 3'd0, 32'h3F800000, 32'h40000000, 5'd7, 32'h40400000, 5'h00, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  op;
      logic [2:0]  rm;
      logic [4:0]  fl;
      logic        ill;
      logic [2:0]  frm;
      logic [7:0]  nf;
      if ($urandom_range(0, 3) == 0) csr_write(8'($urandom));
      op  = 6'($urandom_range(0, 20));
      rm  = 3'($urandom_range(0, 7));
      fl  = 5'($urandom);
      frm = rm == 3'd7 ? m_fcsr[7:5] : rm;
      ill = op > 6'd16 || frm > 3'd4;
      nf  = ill ? m_fcsr : {m_fcsr[7:5], m_fcsr[4:0] | fl};
      run_op(op, rm, $urandom, $urandom, 5'($urandom), $urandom, fl, 1'b0, 8'h00, ill, frm, nf,
             int'($urandom_range(0, 2)), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
